// File: rtl/data_array_pkg.sv
// Shared types and default geometry for the L1 data-array bank controller.
// The top-level parameters override this geometry; the helpers take the geometry as arguments.
package data_array_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam int unsigned WAYS_DEF       = 2;
  localparam int unsigned LANES_DEF      = 4;
  localparam int unsigned INDEX_BITS_DEF = 12;
  localparam int unsigned ADDR_BITS_DEF  = 14;

  localparam int unsigned DW       = 8 * LANES_DEF;
  localparam int unsigned OFF      = $clog2(LANES_DEF);
  localparam int unsigned DEPTH    = 2 ** INDEX_BITS_DEF;
  localparam int unsigned WAY_BITS = (WAYS_DEF > 1) ? $clog2(WAYS_DEF) : 1;

  // Word index of a byte address. The caller keeps the low INDEX_BITS of the result,
  // so address bits above the index are discarded and large addresses alias.
  function automatic logic [31:0] idx_of(input logic [63:0] addr, input int unsigned off);
    logic [63:0] v_sh;
    v_sh = addr >> off;
    return v_sh[31:0];
  endfunction

endpackage

// File: rtl/data_array_sram_bank.sv
// Single-port, byte-masked data SRAM bank with synchronous read (1-cycle latency).
module data_array_sram_bank #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned INDEX_BITS = 12
) (
  input  logic                    i_clk,
  input  logic                    i_en,
  input  logic                    i_we,
  input  logic [LANES-1:0]        i_mask,
  input  logic [INDEX_BITS-1:0]   i_addr,
  input  logic [8*LANES-1:0]      i_wdata,
  output logic [8*LANES-1:0]      o_rdata
);

  logic [8*LANES-1:0] r_mem [2**INDEX_BITS];
  logic [8*LANES-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (i_mask[l]) r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_array_bank_ctrl.sv
// WAYS-bank L1 data array: zero-init sweep, refill-over-core arbitration,
// and a registered read response that holds between reads.
module data_array_bank_ctrl
  import data_array_pkg::*;
#(
  parameter int unsigned WAYS       = WAYS_DEF,
  parameter int unsigned LANES      = LANES_DEF,
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  localparam int unsigned WB        = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned LDW       = 8 * LANES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic                 cpu_req_write,
  input  logic [WB-1:0]        cpu_req_way,
  input  logic [ADDR_BITS-1:0] cpu_req_addr,
  input  logic [LANES-1:0]     cpu_req_mask,
  input  logic [LDW-1:0]       cpu_req_wdata,
  output logic                 cpu_resp_valid,
  output logic [LDW-1:0]       cpu_resp_rdata,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [WB-1:0]        fill_way,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [LDW-1:0]       fill_wdata,
  output logic                 init_done
);

  localparam int unsigned LOFF = $clog2(LANES);

  state_e                r_state, w_state_nxt;
  logic [INDEX_BITS-1:0] r_sweep;
  logic                  r_rd_pend;
  logic [WB-1:0]         r_rd_way;
  logic [LDW-1:0]        r_hold;

  logic [31:0]           w_cpu_idx_full, w_fill_idx_full;
  logic [INDEX_BITS-1:0] w_cpu_idx, w_fill_idx;
  logic                  w_cpu_acc;
  logic                  w_unused;

  logic                  w_en    [WAYS];
  logic                  w_we    [WAYS];
  logic [LANES-1:0]      w_mask  [WAYS];
  logic [INDEX_BITS-1:0] w_idx   [WAYS];
  logic [LDW-1:0]        w_wdata [WAYS];
  logic [LDW-1:0]        w_rdata [WAYS];

  assign w_cpu_idx_full  = idx_of(64'(cpu_req_addr), LOFF);
  assign w_fill_idx_full = idx_of(64'(fill_addr), LOFF);
  assign w_cpu_idx       = w_cpu_idx_full[INDEX_BITS-1:0];
  assign w_fill_idx      = w_fill_idx_full[INDEX_BITS-1:0];
  assign w_unused        = ^{w_cpu_idx_full, w_fill_idx_full};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_sweep <= r_sweep + 1'b1;
    end
  end

  // Ready depends only on state and fill_valid, never on cpu_req_valid.
  always_comb begin
    w_state_nxt   = r_state;
    cpu_req_ready = 1'b0;
    fill_ready    = 1'b0;
    init_done     = 1'b0;
    case (r_state)
      INIT: if (r_sweep == '1) w_state_nxt = RUN;
      RUN: begin
        init_done     = 1'b1;
        fill_ready    = 1'b1;
        cpu_req_ready = ~fill_valid;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  assign w_cpu_acc = cpu_req_valid & cpu_req_ready;

  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_en[w]    = 1'b0;
      w_we[w]    = 1'b0;
      w_mask[w]  = '0;
      w_idx[w]   = '0;
      w_wdata[w] = '0;
      if (r_state == INIT) begin
        w_en[w]   = 1'b1;
        w_we[w]   = 1'b1;
        w_mask[w] = '1;
        w_idx[w]  = r_sweep;
      end else if (fill_valid && fill_way == WB'(w)) begin
        w_en[w]    = 1'b1;
        w_we[w]    = 1'b1;
        w_mask[w]  = '1;
        w_idx[w]   = w_fill_idx;
        w_wdata[w] = fill_wdata;
      end else if (w_cpu_acc && cpu_req_way == WB'(w)) begin
        w_en[w]    = 1'b1;
        w_we[w]    = cpu_req_write;
        w_mask[w]  = cpu_req_write ? cpu_req_mask : '0;
        w_idx[w]   = w_cpu_idx;
        w_wdata[w] = cpu_req_wdata;
      end
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_bank
    data_array_sram_bank #(
      .LANES      (LANES),
      .INDEX_BITS (INDEX_BITS)
    ) u_bank (
      .i_clk   (clock),
      .i_en    (w_en[g]),
      .i_we    (w_we[g]),
      .i_mask  (w_mask[g]),
      .i_addr  (w_idx[g]),
      .i_wdata (w_wdata[g]),
      .o_rdata (w_rdata[g])
    );
  end

  // Response data is taken straight from the bank in the cycle after acceptance,
  // then captured into r_hold so the output stays put between responses.
  assign cpu_resp_valid = r_rd_pend;
  assign cpu_resp_rdata = r_rd_pend ? w_rdata[r_rd_way] : r_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_way  <= '0;
      r_hold    <= '0;
    end else begin
      r_rd_pend <= w_cpu_acc & ~cpu_req_write;
      if (w_cpu_acc) r_rd_way <= cpu_req_way;
      r_hold    <= cpu_resp_rdata;
    end
  end

endmodule
